// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle shortcuts for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, stateNext;

  logic [2:0]        op;
  logic [XLEN-1:0]   magA, magB, quo, rem;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic              signA, signB;

  // Operand decode for the op being launched this cycle
  logic            aSigned, bSigned, inSignA, inSignB, divZero, divOvf, special;
  logic [XLEN-1:0] inMagA, inMagB, specialRes;

  always_comb begin
    aSigned    = !(funct3[0] && (funct3[2] || funct3[1]));
    bSigned    = aSigned && (funct3 != 3'b010);
    inSignA    = aSigned && a[XLEN-1];
    inSignB    = bSigned && b[XLEN-1];
    inMagA     = inSignA ? -a : a;
    inMagB     = inSignB ? -b : b;
    divZero    = funct3[2] && (b == '0);
    divOvf     = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    special    = divZero || divOvf;
    // Overflow quotient equals the dividend itself (most negative value)
    specialRes = divZero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
  end

  // Restoring divide step: remainder is one bit wider before the compare
  logic [XLEN:0]   remShift;
  logic [XLEN-1:0] remSub;
  logic            remGe;

  always_comb begin
    remShift = {rem, quo[XLEN-1]};
    remGe    = remShift >= {1'b0, magB};
    remSub   = remShift[XLEN-1:0] - magB;
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quoF, remF, fixRes;

  always_comb begin
    prod = (signA ^ signB) ? -acc : acc;
    quoF = (signA ^ signB) ? -quo : quo;
    remF = signA ? -rem : rem;
    case (op)
      3'b000:                 fixRes = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixRes = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixRes = quoF;
      default:                fixRes = remF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start && !kill) stateNext = special ? DONE : (funct3[2] ? DIV : MUL);
      MUL, DIV: if (count == '0) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (kill && state != IDLE) stateNext = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= '0;
      magA   <= '0;
      magB   <= '0;
      quo    <= '0;
      rem    <= '0;
      acc    <= '0;
      count  <= '0;
      signA  <= 1'b0;
      signB  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start && !kill) begin
          op    <= funct3;
          magA  <= inMagA;
          magB  <= inMagB;
          signA <= inSignA;
          signB <= inSignB;
          quo   <= inMagA;
          rem   <= '0;
          acc   <= '0;
          count <= CW'(XLEN-1);
          if (special) result <= specialRes;
        end
        // MSB-first shift-add: same sum as adding |a|<<i for each set bit i
        MUL: begin
          acc   <= {acc[2*XLEN-2:0], 1'b0} + (magB[count] ? {{XLEN{1'b0}}, magA} : '0);
          count <= count - CW'(1);
        end
        DIV: begin
          rem   <= remGe ? remSub : remShift[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], remGe};
          count <= count - CW'(1);
        end
        FIX: if (!kill) result <= fixRes;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with latency counter, per-cycle
// compare of busy/done/result, plus directed vectors with literal expected results.
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0, errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refRes(input logic [2:0] f, input logic [31:0] x,
                                         input logic [31:0] y);
    int ix, iy;
    longint sx, sy, uy, sp;
    logic [63:0] up;
    ix = x; iy = y; sx = ix; sy = iy; uy = {32'b0, y};
    case (f)
      3'd0: begin sp = sx * sy; up = sp; return up[31:0]; end
      3'd1: begin sp = sx * sy; up = sp; return up[63:32]; end
      3'd2: begin sp = sx * uy; up = sp; return up[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        sp = sx / sy; up = sp; return up[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        sp = sx % sy; up = sp; return up[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic isSpecial(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
    return f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  // Model: remaining cycles until done; result becomes visible on entering done
  logic        mBusy = 1'b0;
  int          mCnt = 0;
  logic [31:0] mRes = '0, mPend = '0;

  always @(posedge clk) begin
    if (reset) begin
      mBusy <= 1'b0; mCnt <= 0; mRes <= '0;
    end else if (mBusy && kill) begin
      mBusy <= 1'b0;
    end else if (mBusy) begin
      if (mCnt == 0) mBusy <= 1'b0;
      else begin
        mCnt <= mCnt - 1;
        if (mCnt == 1) mRes <= mPend;
      end
    end else if (start && !kill) begin
      mBusy <= 1'b1;
      if (isSpecial(funct3, a, b)) begin
        mCnt <= 0; mRes <= refRes(funct3, a, b);
      end else begin
        mCnt <= 33; mPend <= refRes(funct3, a, b);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(mBusy));
    chk("done", 32'(done), 32'(mBusy && mCnt == 0));
    chk("result", result, mRes);
  end

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] lit, input int lat);
    int n;
    @(negedge clk); start = 1'b1; funct3 = f; a = x; b = y;
    @(negedge clk); start = 1'b0;
    waitDone(n);
    chk({name, " res"}, result, lit);
    chk({name, " lat"}, n, lat);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst result", result, 32'h0);
    reset = 1'b0;

    runOp("mul 7*-3",     3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    runOp("mulh 7*-3",    3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    runOp("mulhu max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    runOp("mulhsu -1*2",  3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    runOp("mulh min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    runOp("mulhsu min",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    runOp("mul 0*5",      3'd0, 32'd0, 32'd5, 32'd0, 33);
    runOp("div -7/2",     3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    runOp("rem -7%2",     3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    runOp("div 7/-2",     3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    runOp("rem 7%-2",     3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    runOp("divu 100/7",   3'd5, 32'd100, 32'd7, 32'd14, 33);
    runOp("remu 100%7",   3'd7, 32'd100, 32'd7, 32'd2, 33);
    runOp("divu bigdiv",  3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    runOp("remu bigdiv",  3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    runOp("div 5/0",      3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    runOp("rem 5%0",      3'd6, 32'd5, 32'd0, 32'd5, 0);
    runOp("divu 5/0",     3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    runOp("remu 5%0",     3'd7, 32'd5, 32'd0, 32'd5, 0);
    runOp("div ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    runOp("rem ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);

    // start and operand changes while busy are ignored
    @(negedge clk); start = 1'b1; funct3 = 3'd0; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk); funct3 = 3'd4; a = 32'd5; b = 32'd0;
    repeat (4) @(negedge clk);
    start = 1'b0;
    waitDone(n);
    chk("busy-start res", result, 32'hFFFFFFEB);

    // start held through done: ignored in done cycle, accepted one cycle later
    @(negedge clk); start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd4;
    waitDone(n);
    chk("held first res", result, 32'd12);
    a = 32'd5; b = 32'd6;
    @(negedge clk);
    chk("held gap busy", 32'(busy), 32'h0);
    @(negedge clk); start = 1'b0;
    chk("held reaccept busy", 32'(busy), 32'h1);
    waitDone(n);
    chk("held second res", result, 32'd30);
    chk("held second lat", n, 33);

    // kill mid-divide, then an immediate new start
    runOp("divu pre-kill", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk); start = 1'b1; funct3 = 3'd4; a = 32'hFFFFFFF9; b = 32'd2;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("kill busy", 32'(busy), 32'h0);
    chk("kill done", 32'(done), 32'h0);
    chk("kill result", result, 32'd14);
    start = 1'b1; funct3 = 3'd7; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    chk("post-kill accept", 32'(busy), 32'h1);
    waitDone(n);
    chk("post-kill res", result, 32'd2);
    chk("post-kill lat", n, 33);

    // kill together with start in idle is not accepted
    @(negedge clk); start = 1'b1; kill = 1'b1; funct3 = 3'd4; a = 32'd5; b = 32'd0;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    chk("kill+start busy", 32'(busy), 32'h0);
    chk("kill+start result", result, 32'd2);

    // reset mid-op
    @(negedge clk); start = 1'b1; funct3 = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    chk("midrst result", result, 32'h0);
    runOp("mul after rst", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
